// File: rtl/mux_arb_nto1_if.sv
// Bundle of producer-side and consumer-side signals around the N-to-1 registered mux.
// "slave" is the mux itself; "master" is whatever drives the channels and consumes the output.
interface mux_arb_nto1_if #(
  parameter int W  = 8,
  parameter int N  = 16,
  parameter int SW = $clog2(N)
);
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_arb_nto1.sv
// Registered N-to-1 mux with fixed-select or work-conserving round-robin grant,
// per-channel valid/ready on the inputs and a single valid/ready output register.
module mux_arb_nto1 #(
  parameter int W  = 8,
  parameter int N  = 16,
  parameter int SW = $clog2(N)
) (
  input logic            clk,
  input logic            rst,
  mux_arb_nto1_if.slave  bus
);

  logic [W-1:0]  outData_q, outData_d;
  logic [SW-1:0] outCh_q, outCh_d;
  logic          outValid_q, outValid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic [W-1:0]  chData [N];
  logic [SW-1:0] rrGrant;
  logic          rrFound;
  logic [SW:0]   idxSum;
  logic [SW-1:0] idx;
  logic          fixValid;
  logic [SW-1:0] grant;
  logic          gntV;
  logic          loadEn;
  logic          xfer;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      chData[i] = bus.in_data[i*W +: W];
    end
  end

  // Scan ptr, ptr+1, ... with wrap at N (not at 2**SW) so non-power-of-two N works.
  always_comb begin
    rrGrant = '0;
    rrFound = 1'b0;
    idxSum  = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idxSum = {1'b0, ptr_q} + (SW+1)'(k);
      if (idxSum >= (SW+1)'(N)) begin
        idxSum = idxSum - (SW+1)'(N);
      end
      idx = idxSum[SW-1:0];
      if (!rrFound && bus.in_valid[idx]) begin
        rrFound = 1'b1;
        rrGrant = idx;
      end
    end
  end

  always_comb begin
    fixValid = 1'b0;
    if (int'(bus.sel) < N) begin
      fixValid = bus.in_valid[bus.sel];
    end
    grant  = bus.mode ? rrGrant : bus.sel;
    gntV   = bus.mode ? rrFound : fixValid;
    loadEn = !outValid_q || bus.out_ready;
    xfer   = loadEn && gntV;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.in_ready[i] = !rst && xfer && (grant == SW'(i));
    end
  end

  // Output register and pointer only move on a transfer; a stall holds everything.
  always_comb begin
    outData_d  = outData_q;
    outCh_d    = outCh_q;
    outValid_d = outValid_q;
    ptr_d      = ptr_q;
    if (xfer) begin
      outData_d  = chData[grant];
      outCh_d    = grant;
      outValid_d = 1'b1;
      if (bus.mode) begin
        ptr_d = (grant == SW'(N-1)) ? '0 : grant + 1'b1;
      end
    end else if (loadEn) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outData_q  <= '0;
      outCh_q    <= '0;
      outValid_q <= 1'b0;
      ptr_q      <= '0;
    end else begin
      outData_q  <= outData_d;
      outCh_q    <= outCh_d;
      outValid_q <= outValid_d;
      ptr_q      <= ptr_d;
    end
  end

  assign bus.out_data  = outData_q;
  assign bus.out_ch    = outCh_q;
  assign bus.out_valid = outValid_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed bench for mux_arb_nto1 (W=8, N=16): reset, fixed select, round-robin
// fairness, skip/wrap, backpressure and mid-stream reset, with hand-computed expectations.
module tb_mux_arb_nto1;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int SW = $clog2(N);

  logic clk;
  logic rst;
  int   testsRun;
  int   testsFailed;

  mux_arb_nto1_if #(.W(W), .N(N), .SW(SW)) bus ();

  mux_arb_nto1 #(.W(W), .N(N), .SW(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [N-1:0] valid, input logic modeIn,
                               input logic [SW-1:0] selIn, input logic outReady);
    bus.in_valid  = valid;
    bus.mode      = modeIn;
    bus.sel       = selIn;
    bus.out_ready = outReady;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWord(input string tag, input logic [SW-1:0] ch, input logic [W-1:0] data);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_ch"},    32'(bus.out_ch),    32'(ch));
    checkOutput({tag, "_data"},  32'(bus.out_data),  32'(data));
  endtask

  initial begin
    int skipSeq [6];
    testsRun    = 0;
    testsFailed = 0;
    skipSeq     = '{3, 9, 14, 3, 9, 14};

    for (int i = 0; i < N; i++) begin
      bus.in_data[i*W +: W] = 8'h40 + 8'(i);
    end
    bus.in_data[5*W +: W] = 8'hA5;
    bus.in_data[7*W +: W] = 8'h3C;

    // Reset with every channel requesting
    rst = 1'b1;
    applyStimulus('1, 1'b1, '0, 1'b1);
    checkOutput("rst_inready", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_data",  32'(bus.out_data),  32'd0);
    checkOutput("rst_ch",    32'(bus.out_ch),    32'd0);
    checkOutput("rst_inready_hold", 32'(bus.in_ready), 32'd0);

    // Round-robin fairness, all valid, back-to-back transfers (channel 5 carries 0xA5)
    rst = 1'b0;
    applyStimulus('1, 1'b1, '0, 1'b1);
    for (int k = 0; k < 32; k++) begin
      int ch;
      logic [W-1:0] expData;
      ch = k % N;
      expData = (ch == 5) ? 8'hA5 : (ch == 7) ? 8'h3C : 8'h40 + 8'(ch);
      checkOutput($sformatf("rr_inready_%0d", k), 32'(bus.in_ready), 32'(1) << ch);
      tick();
      checkWord($sformatf("rr_%0d", k), SW'(ch), expData);
    end

    // Fixed select on channel 5
    applyStimulus('1, 1'b0, SW'(5), 1'b1);
    checkOutput("fix_inready", 32'(bus.in_ready), 32'h0000_0020);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkWord($sformatf("fix_%0d", k), SW'(5), 8'hA5);
    end

    // Fixed select on an idle channel: output empties, data/ch hold
    applyStimulus(16'h7FFF, 1'b0, SW'(15), 1'b1);
    checkOutput("fix_idle_inready", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("fix_idle_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("fix_idle_data",  32'(bus.out_data),  32'hA5);
    checkOutput("fix_idle_ch",    32'(bus.out_ch),    32'd5);

    // Skip and wrap; pointer is still 0 because fixed mode never moves it
    applyStimulus(16'h4208, 1'b1, '0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("skip_ch_%0d", k), 32'(bus.out_ch), 32'(skipSeq[k]));
    end
    applyStimulus(16'h4200, 1'b1, '0, 1'b1);
    tick();
    checkOutput("drop3_ch", 32'(bus.out_ch), 32'd9);
    tick();
    checkOutput("drop3_ch2", 32'(bus.out_ch), 32'd14);

    // Load channel 7 (pointer at 15 wraps through 0..7), then stall 4 cycles
    applyStimulus(16'h0080, 1'b1, '0, 1'b1);
    tick();
    checkWord("bp_load", SW'(7), 8'h3C);
    applyStimulus('1, 1'b1, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("bp_inready_%0d", k), 32'(bus.in_ready), 32'd0);
      tick();
      checkWord($sformatf("bp_hold_%0d", k), SW'(7), 8'h3C);
    end
    applyStimulus('1, 1'b1, '0, 1'b1);
    checkOutput("bp_release_inready", 32'(bus.in_ready), 32'h0000_0100);
    tick();
    checkWord("bp_release", SW'(8), 8'h48);

    // Reset while a word is stalled in the output register (pointer is 9 here)
    applyStimulus(16'h1010, 1'b1, '0, 1'b0);
    tick();
    checkWord("mid_stall", SW'(8), 8'h48);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_inready", 32'(bus.in_ready), 32'd0);
    tick();
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_data",  32'(bus.out_data),  32'd0);
    checkOutput("mid_rst_ch",    32'(bus.out_ch),    32'd0);
    rst = 1'b0;
    applyStimulus(16'h1010, 1'b1, '0, 1'b0);
    checkOutput("post_rst_inready", 32'(bus.in_ready), 32'h0000_0010);
    tick();
    checkWord("post_rst", SW'(4), 8'h44);
    checkOutput("post_rst_stall_inready", 32'(bus.in_ready), 32'd0);
    tick();
    checkWord("post_rst_hold", SW'(4), 8'h44);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mux_arb_nto1.md
# mux_arb_nto1

Parametrised, registered N-to-1 data multiplexer, the sequential successor to the fixed-width gate-level 2:1/4:1/16:1 mux tree. Supports W-bit channels, any channel count N ≥ 2 (not restricted to a power of two), and two selection modes: externally driven fixed select, or a work-conserving round-robin scan over valid channels. Per-channel valid/ready handshakes on the inputs and a registered valid/ready output let it sit between multiple producers and a single downstream consumer.

## Interface

- W, 8: data width per channel, ≥ 1.
- N, 16: channel count, ≥ 2.
- SW, $clog2(N): select/channel-index width, derived; not overridden.

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  channel i holds a word.
- in_ready  output  N  channel i word accepted this cycle; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SW  channel index in fixed mode; ignored in round-robin mode.
- out_data  output  W  registered selected word.
- out_ch  output  SW  registered index of the channel that supplied out_data.
- out_valid  output  1  out_data/out_ch hold a word.
- out_ready  input  1  consumer accepts the word this cycle.

## Operation

- State: output register (out_data, out_ch, out_valid) and round-robin pointer ptr[SW].
- load_en = !out_valid || out_ready.
- Grant, fixed mode: grant = sel and gnt_v = in_valid[sel]. If sel ≥ N, gnt_v = 0.
- Grant, round-robin mode: grant is the first i with in_valid[i] = 1, searched in order ptr, ptr+1, …, N-1, 0, …, ptr-1. gnt_v = |in_valid.
- in_ready[i] = load_en && gnt_v && (grant == i). At most one bit is set. It does not depend on in_valid of other channels beyond grant selection.
- Transfer on the edge when load_en && gnt_v:
  - out_data <= in_data[grant];
  - out_ch <= grant;
  - out_valid <= 1.
- If load_en && !gnt_v: out_valid <= 0. out_data and out_ch hold their previous values.
- If !load_en: the output register holds (stall). No input is accepted.
- ptr update: only in round-robin mode and only on a transfer, ptr <= (grant + 1) mod N, wrapping from N-1 to 0. Otherwise ptr holds, including throughout fixed mode.
- Mode and sel are sampled every cycle. A change affects the next grant only and never alters a word already in the output register.
- Reset: out_valid = 0, out_data = 0, out_ch = 0, ptr = 0. Any pending output word is discarded. in_ready is all zeros while rst = 1.

## Timing

- Latency: a word accepted at edge k (in_ready high in cycle k-1) appears on out_data/out_valid after edge k, i.e. 1 cycle.
- Throughput: 1 word per cycle while out_ready = 1 and some channel is valid.
- Output stability: while out_valid && !out_ready, out_data and out_ch must not change.
- Simultaneous out_ready and new grant in the same cycle: the old word leaves and the new word loads at the same edge, with no bubble.
- Fairness: in round-robin mode with all N channels continuously valid and out_ready = 1, each channel is granted exactly once per N consecutive transfers.
- No combinational path from in_data to out_data. in_valid/sel/mode/out_ready to in_ready is combinational.

## Test plan

- Reset: assert rst with all in_valid = 1 -> in_ready = 0, and after the edge out_valid = 0, out_data = 0x00, out_ch = 0. Deassert rst, round-robin, out_ready = 1 -> first out_ch = 0.
- Fixed select: mode = 0, sel = 5, in_data[5] = 0xA5, all valid, out_ready = 1 -> out_data = 0xA5, out_ch = 5 every cycle. Only in_ready[5] is high. Set sel = 16 when N = 17 is not configured (N = 16, so sel = 15 max); with in_valid[15] = 0 -> out_valid drops to 0.
- Round-robin fairness: mode = 1, all 16 channels valid, channel i data = i, out_ready = 1 for 32 cycles -> out_ch sequence 0,1,…,15,0,…,15.
- Skip and wrap: valid only on channels 3, 9 and 14, ptr = 0 -> grants 3, 9, 14, 3, … Then drop channel 3 after a grant of 14 -> next grant is 9.
- Backpressure: out_ready = 0 for 4 cycles with word 0x3C from channel 7 loaded -> out_data = 0x3C and out_ch = 7 held, all in_ready = 0, ptr frozen. Release -> next grant is channel 8 if valid.
- Reset mid-stream: assert rst while out_valid = 1 and out_ready = 0 -> the word is discarded, ptr = 0, and after release the first round-robin grant is the lowest valid channel.
